// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The arbiter connects through the slave modport; the environment that owns the
// masters and the memory connects through the master modport.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;

    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_in;
    logic          we;
    logic [1:0]    owner;

    modport slave (
        input  m0_req, m0_we, m0_address, m0_wdata,
        input  m1_req, m1_we, m1_address, m1_wdata,
        input  data_in,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output address, data_out, we, owner
    );

    modport master (
        output m0_req, m0_we, m0_address, m0_wdata,
        output m1_req, m1_we, m1_address, m1_wdata,
        output data_in,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  address, data_out, we, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port memory bus.
// The current owner gets one access per cycle; once it has done MAX_BURST
// accesses in a row while the other master waits, ownership passes over.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | nobody owns the bus, all bus outputs forced to zero
//  OWN0    | master 0 drives the memory bus, acked whenever it requests
//  OWN1    | master 1 drives the memory bus, acked whenever it requests
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           resetn,
    mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t          r_st;
    logic [CW-1:0]   r_burst_cnt;
    logic            r_last;

    logic            w_own_idx;
    logic            w_own_req;
    logic            w_oth_req;
    state_t          w_oth_st;

    // last == 1 means master 1 was served last, so master 0 wins a tie
    function automatic state_t f_pick(input logic r0, input logic r1, input logic last);
        state_t st;
        if (r0 && r1)
            st = last ? ST_OWN0 : ST_OWN1;
        else if (r0)
            st = ST_OWN0;
        else if (r1)
            st = ST_OWN1;
        else
            st = ST_IDLE;
        return st;
    endfunction

    assign w_own_idx = (r_st == ST_OWN1);
    assign w_own_req = w_own_idx ? bus.m1_req : bus.m0_req;
    assign w_oth_req = w_own_idx ? bus.m0_req : bus.m1_req;
    assign w_oth_st  = w_own_idx ? ST_OWN0 : ST_OWN1;

    // Ownership, burst counting and round-robin history
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_st        <= ST_IDLE;
            r_burst_cnt <= '0;
            r_last      <= 1'b1;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    r_st        <= f_pick(bus.m0_req, bus.m1_req, r_last);
                    r_burst_cnt <= ONE_CNT;
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_own_req) begin
                        if (w_oth_req && (r_burst_cnt == MAX_CNT)) begin
                            r_st        <= w_oth_st;
                            r_burst_cnt <= ONE_CNT;
                            r_last      <= w_own_idx;
                        end else if (r_burst_cnt != MAX_CNT) begin
                            r_burst_cnt <= r_burst_cnt + ONE_CNT;
                        end
                    end else begin
                        // Owner let go: hand over immediately so a waiting master loses no cycle
                        r_st        <= f_pick(bus.m0_req, bus.m1_req, w_own_idx);
                        r_burst_cnt <= ONE_CNT;
                        r_last      <= w_own_idx;
                    end
                end
                default: begin
                    r_st        <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    // Bus steering from the owner; reset gates we and acks so nothing commits mid-reset
    always_comb begin
        bus.address  = {AW{1'b0}};
        bus.data_out = {DW{1'b0}};
        bus.we       = 1'b0;
        bus.m0_ack   = 1'b0;
        bus.m1_ack   = 1'b0;
        bus.m0_rdata = {DW{1'b0}};
        bus.m1_rdata = {DW{1'b0}};
        bus.owner    = 2'd0;
        case (r_st)
            ST_OWN0: begin
                bus.address  = bus.m0_address;
                bus.data_out = bus.m0_wdata;
                bus.we       = bus.m0_we & bus.m0_req & resetn;
                bus.m0_ack   = bus.m0_req & resetn;
                bus.m0_rdata = bus.data_in;
                bus.owner    = 2'd1;
            end
            ST_OWN1: begin
                bus.address  = bus.m1_address;
                bus.data_out = bus.m1_wdata;
                bus.we       = bus.m1_we & bus.m1_req & resetn;
                bus.m1_ack   = bus.m1_req & resetn;
                bus.m1_rdata = bus.data_in;
                bus.owner    = 2'd2;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // model: who owns the bus (0 none, 1 master0, 2 master1), run length, last served master
    int mdl_owner = 0;
    int mdl_run   = 0;
    int mdl_last  = 1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // memory contents are a fixed function of address
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] v;
        if (a == 32'h0000_0800) v = 32'hDEAD_BEEF;
        else                    v = {a[15:0] ^ 16'h5A3C, ~a[15:0]};
        return v;
    endfunction

    assign bus.data_in = mem_val(bus.address);

    function automatic logic [132:0] observe();
        return {bus.owner, bus.we, bus.address, bus.data_out,
                bus.m0_ack, bus.m0_rdata, bus.m1_ack, bus.m1_rdata};
    endfunction

    function automatic logic [132:0] expect_out();
        logic [1:0]  o;
        logic        w, k0, k1;
        logic [31:0] a, d, r0, r1;
        o = 2'(mdl_owner); w = 1'b0; k0 = 1'b0; k1 = 1'b0;
        a = '0; d = '0; r0 = '0; r1 = '0;
        if (mdl_owner == 1) begin
            a = bus.m0_address; d = bus.m0_wdata;
            k0 = bus.m0_req && resetn; w = k0 && bus.m0_we; r0 = mem_val(a);
        end else if (mdl_owner == 2) begin
            a = bus.m1_address; d = bus.m1_wdata;
            k1 = bus.m1_req && resetn; w = k1 && bus.m1_we; r1 = mem_val(a);
        end
        return {o, w, a, d, k0, r0, k1, r1};
    endfunction

    function automatic int pick(input bit r0, input bit r1, input int last);
        int p;
        if (r0 && r1) p = (last == 0) ? 2 : 1;
        else if (r0)  p = 1;
        else if (r1)  p = 2;
        else          p = 0;
        return p;
    endfunction

    // apply the arbitration rules to the requests that the coming edge will sample
    task automatic mdl_advance();
        bit r0, r1, mine, other;
        int me;
        r0 = bus.m0_req; r1 = bus.m1_req;
        if (!resetn) begin
            mdl_owner = 0; mdl_run = 0; mdl_last = 1;
        end else if (mdl_owner == 0) begin
            mdl_owner = pick(r0, r1, mdl_last); mdl_run = 1;
        end else begin
            me    = mdl_owner - 1;
            mine  = (me == 0) ? r0 : r1;
            other = (me == 0) ? r1 : r0;
            if (mine) begin
                if (other && mdl_run >= MAXB) begin
                    mdl_owner = 2 - me; mdl_run = 1; mdl_last = me;
                end else if (mdl_run < MAXB) begin
                    mdl_run++;
                end
            end else begin
                mdl_last = me; mdl_owner = pick(r0, r1, me); mdl_run = 1;
            end
        end
    endtask

    task automatic next_cycle();
        mdl_advance();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.m0_req = rq; bus.m0_we = w; bus.m0_address = a; bus.m0_wdata = d;
    endtask

    task automatic set_m1(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.m1_req = rq; bus.m1_we = w; bus.m1_address = a; bus.m1_wdata = d;
    endtask

    task automatic settle();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        repeat (2) begin #1; next_cycle(); end
    endtask

    task automatic test_reset();
        set_m0(1'b1, 1'b1, 32'h100, 32'hCAFE_0001);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({bus.we, bus.m0_ack, bus.m1_ack, bus.owner} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_quiet[%0d]: got we/ack0/ack1/owner=%b want 00000", i,
                         {bus.we, bus.m0_ack, bus.m1_ack, bus.owner});
            end
            next_cycle();
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (bus.m0_ack !== 1'b0) begin
            n_errors++; $display("FAIL reset_release_latency: got ack %b want 0", bus.m0_ack);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.m0_ack, bus.we, bus.owner, bus.address} !== {1'b1, 1'b1, 2'd1, 32'h100}) begin
            n_errors++;
            $display("FAIL reset_first_ack: got ack=%b we=%b owner=%0d addr=%h want 1 1 1 00000100",
                     bus.m0_ack, bus.we, bus.owner, bus.address);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_single_read();
        set_m0(1'b1, 1'b0, 32'h800, 32'h0);
        #1;
        n_checks++;
        if (bus.m0_ack !== 1'b0) begin
            n_errors++; $display("FAIL read_grant_latency: got ack %b want 0", bus.m0_ack);
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.address, bus.m0_ack, bus.m0_rdata, bus.we} !== {32'h800, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_errors++;
            $display("FAIL read_data: got addr=%h ack=%b rdata=%h we=%b want 00000800 1 deadbeef 0",
                     bus.address, bus.m0_ack, bus.m0_rdata, bus.we);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_tie();
        resetn = 1'b0;
        #1; next_cycle();
        resetn = 1'b1;
        set_m0(1'b1, 1'b0, 32'h40, 32'h0);
        set_m1(1'b1, 1'b0, 32'h80, 32'h0);
        #1; next_cycle();
        #1;
        n_checks++;
        if ({bus.owner, bus.m0_ack, bus.m1_ack} !== {2'd1, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL tie_first: got owner=%0d ack0=%b ack1=%b want 1 1 0",
                     bus.owner, bus.m0_ack, bus.m1_ack);
        end
        next_cycle();
        bus.m0_req = 1'b0;
        #1;
        n_checks++;
        if (observe() !== expect_out()) begin
            n_errors++; $display("FAIL tie_release: got %h want %h", observe(), expect_out());
        end
        next_cycle();
        #1;
        n_checks++;
        if ({bus.owner, bus.m0_ack, bus.m1_ack, bus.m1_rdata} !== {2'd2, 1'b0, 1'b1, mem_val(32'h80)}) begin
            n_errors++;
            $display("FAIL tie_second: got owner=%0d ack0=%b ack1=%b rdata=%h want 2 0 1 %h",
                     bus.owner, bus.m0_ack, bus.m1_ack, bus.m1_rdata, mem_val(32'h80));
        end
        next_cycle();
        settle();
    endtask

    task automatic test_burst_limit();
        int m0_done, m1_done;
        int seq[$];
        bit both;
        logic [10:0] got_bits;
        m0_done = 0; m1_done = 0; both = 1'b0; got_bits = '0;
        for (int c = 0; c < 40 && m0_done < 10; c++) begin
            set_m0(m0_done < 10, 1'b0, 32'h1000 + 32'(m0_done * 4), 32'h0);
            set_m1((c >= 2) && (m1_done == 0), 1'b0, 32'h2000, 32'h0);
            #1;
            n_checks++;
            if (observe() !== expect_out()) begin
                n_errors++; $display("FAIL burst_model[%0d]: got %h want %h", c, observe(), expect_out());
            end
            if (bus.m0_ack && bus.m1_ack) both = 1'b1;
            if (bus.m0_ack === 1'b1) begin seq.push_back(0); m0_done++; end
            if (bus.m1_ack === 1'b1) begin seq.push_back(1); m1_done++; end
            next_cycle();
        end
        n_checks++;
        if (m0_done != 10 || m1_done != 1) begin
            n_errors++; $display("FAIL burst_counts: got m0=%0d m1=%0d want 10 1", m0_done, m1_done);
        end
        for (int i = 0; i < seq.size() && i < 11; i++) got_bits[10-i] = seq[i][0];
        n_checks++;
        if (seq.size() != 11 || got_bits !== 11'b00001000000) begin
            n_errors++;
            $display("FAIL burst_order: got %0d acks order %b want 11 acks order 00001000000",
                     seq.size(), got_bits);
        end
        n_checks++;
        if (both) begin
            n_errors++; $display("FAIL burst_double_ack: got both acks in one cycle want never");
        end
        settle();
    endtask

    task automatic test_write();
        set_m1(1'b1, 1'b1, 32'h804, 32'h1234_5678);
        #1; next_cycle();
        #1;
        n_checks++;
        if ({bus.we, bus.address, bus.data_out, bus.m1_ack, bus.owner} !==
            {1'b1, 32'h804, 32'h1234_5678, 1'b1, 2'd2}) begin
            n_errors++;
            $display("FAIL write_pass: got we=%b addr=%h data=%h ack1=%b owner=%0d want 1 00000804 12345678 1 2",
                     bus.we, bus.address, bus.data_out, bus.m1_ack, bus.owner);
        end
        next_cycle();
        bus.m1_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.we, bus.m1_ack} !== 2'b00) begin
            n_errors++; $display("FAIL write_single_cycle: got we=%b ack1=%b want 0 0", bus.we, bus.m1_ack);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_reset_mid();
        set_m1(1'b1, 1'b1, 32'h900, 32'h1111_0000);
        #1; next_cycle();
        #1;
        n_checks++;
        if ({bus.we, bus.m1_ack} !== 2'b11) begin
            n_errors++; $display("FAIL midrst_write1: got we=%b ack1=%b want 1 1", bus.we, bus.m1_ack);
        end
        next_cycle();
        set_m1(1'b1, 1'b1, 32'h904, 32'h1111_0001);
        #1; next_cycle();
        set_m1(1'b1, 1'b1, 32'h908, 32'h1111_0002);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.we, bus.m1_ack, bus.m0_ack} !== 3'b000) begin
            n_errors++;
            $display("FAIL midrst_suppress: got we=%b ack1=%b ack0=%b want 0 0 0", bus.we, bus.m1_ack, bus.m0_ack);
        end
        next_cycle();
        resetn = 1'b1;
        bus.m1_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.owner, bus.we, bus.m1_ack} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst_idle: got owner=%0d we=%b ack1=%b want 0 0 0", bus.owner, bus.we, bus.m1_ack);
        end
        next_cycle();
        settle();
    endtask

    task automatic test_random();
        logic q0, q1, we0, we1, e0, e1;
        logic [31:0] a0, a1, d0, d1;
        int acks0, acks1;
        q0 = 1'b0; q1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; acks0 = 0; acks1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (!q0 && $urandom_range(0, 9) < 6) begin
                q0 = 1'b1; we0 = 1'($urandom_range(0, 1)); a0 = $urandom & 32'h0000_0FFC; d0 = $urandom;
            end
            if (!q1 && $urandom_range(0, 9) < 6) begin
                q1 = 1'b1; we1 = 1'($urandom_range(0, 1)); a1 = $urandom & 32'h0000_0FFC; d1 = $urandom;
            end
            resetn = ($urandom_range(0, 59) != 0);
            set_m0(q0, we0, a0, d0);
            set_m1(q1, we1, a1, d1);
            #1;
            n_checks++;
            if (observe() !== expect_out()) begin
                n_errors++; $display("FAIL random_model[%0d]: got %h want %h", i, observe(), expect_out());
            end
            n_checks++;
            if (bus.m0_ack && bus.m1_ack) begin
                n_errors++; $display("FAIL random_double_ack[%0d]: got 1 1 want at most one", i);
            end
            e0 = (mdl_owner == 1) && q0 && resetn;
            e1 = (mdl_owner == 2) && q1 && resetn;
            if (e0) begin q0 = 1'b0; acks0++; end
            if (e1) begin q1 = 1'b0; acks1++; end
            next_cycle();
        end
        resetn = 1'b1;
        n_checks++;
        if (acks0 < 50 || acks1 < 50) begin
            n_errors++; $display("FAIL random_progress: got acks %0d/%0d want both >= 50", acks0, acks1);
        end
        settle();
    endtask

    initial begin
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        mdl_owner = 0; mdl_run = 0; mdl_last = 1;
        test_reset();
        test_single_read();
        test_tie();
        test_burst_limit();
        test_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
